// File: rtl/addsub_slice_sequencer.sv
// addsub_slice_sequencer
// Time-multiplexes one shared N-bit add/sub slice over a W = N*SLICES operand.
// Two modes:
//   - mode = 0: full-width. Carry/borrow is chained from slice 0 (LSB) upward.
//   - mode = 1: SIMD. Each slice is an independent lane with its own add/sub select.
// One slice is processed per cycle. The result is held in DONE until it is consumed.
// Optional build macro ADDSUB_SEQ_OVF_EN adds the res_ovf signed-overflow output
// for full-width operations.
module addsub_slice_sequencer #(
  parameter int N      = 4,
  parameter int SLICES = 4,
  localparam int W     = N * SLICES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              mode,
  input  logic              mode_func,
  input  logic [SLICES-1:0] func_lanes,
  input  logic [W-1:0]      op_a,
  input  logic [W-1:0]      op_b,
  input  logic              cin,
  output logic              slc_mode,
  output logic              slc_mode_func,
  output logic              slc_func,
  output logic [N-1:0]      slc_a,
  output logic [N-1:0]      slc_b,
  output logic              slc_c,
  input  logic [N+1:0]      slc_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [SLICES-1:0] lane_flags
`ifdef ADDSUB_SEQ_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [KW-1:0]     k;
  logic              mode_lat;
  logic              mf_lat;
  logic [SLICES-1:0] fl_lat;
  logic [W-1:0]      a_lat;
  logic [W-1:0]      b_lat;
  logic              cin_lat;
  logic              carry;
  logic              cur_sub;
  logic              flag;

  // Carry out of an add is bit N.
  // A subtract borrows when the signed N+2-bit result is negative.
  function automatic logic slice_flag(input logic sub, input logic [N+1:0] r);
    return sub ? r[N+1] : r[N];
  endfunction

`ifdef ADDSUB_SEQ_OVF_EN
  // Two's-complement overflow of the full-width result, taken from the MSBs.
  function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    if (sub) return (a_msb != b_msb) && (r_msb != a_msb);
    else     return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction
`endif

  assign start_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);

  // Select the op for the current slice and extract its carry/borrow flag.
  always_comb begin
    cur_sub = mode_lat ? fl_lat[k] : mf_lat;
    flag    = slice_flag(cur_sub, slc_result);
  end

  // Drive the shared slice only while running; hold it at zero otherwise.
  always_comb begin
    slc_mode      = 1'b0;
    slc_mode_func = 1'b0;
    slc_func      = 1'b0;
    slc_a         = '0;
    slc_b         = '0;
    slc_c         = 1'b0;
    if (state == S_RUN) begin
      slc_mode      = mode_lat;
      slc_mode_func = mf_lat;
      slc_func      = fl_lat[k];
      slc_a         = a_lat[k*N +: N];
      slc_b         = b_lat[k*N +: N];
      if (!mode_lat) slc_c = (k == '0) ? cin_lat : carry;
    end
  end

  // Sequencer FSM: latch request, walk slices LSB first, hold result until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      mode_lat   <= 1'b0;
      mf_lat     <= 1'b0;
      fl_lat     <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      cin_lat    <= 1'b0;
      carry      <= 1'b0;
      res_data   <= '0;
      lane_flags <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
      res_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            mode_lat   <= mode;
            mf_lat     <= mode_func;
            fl_lat     <= func_lanes;
            a_lat      <= op_a;
            b_lat      <= op_b;
            cin_lat    <= cin;
            carry      <= 1'b0;
            res_data   <= '0;
            lane_flags <= '0;
            k          <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
            res_ovf    <= 1'b0;
`endif
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          res_data[k*N +: N] <= slc_result[N-1:0];
          lane_flags[k]      <= flag;
          carry              <= flag;
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_DONE;
`ifdef ADDSUB_SEQ_OVF_EN
            res_ovf <= mode_lat ? 1'b0
                     : signed_ovf(mf_lat, a_lat[W-1], b_lat[W-1], slc_result[N-1]);
`endif
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_slice_sequencer.sv
// Testbench for addsub_slice_sequencer (N=4, SLICES=4).
// Models the shared add/sub slice combinationally.
// Expected results go into a scoreboard queue when a request is issued and are
// compared when the result handshake completes.
// Build with +define+ADDSUB_SEQ_OVF_EN to also cover res_ovf.
module tb_addsub_slice_sequencer;

  localparam int N      = 4;
  localparam int SLICES = 4;
  localparam int W      = N * SLICES;

  typedef struct packed {
    logic [W-1:0]      data;
    logic [SLICES-1:0] flags;
    logic              ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic              mode;
  logic              mode_func;
  logic [SLICES-1:0] func_lanes;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              cin;
  logic              slc_mode;
  logic              slc_mode_func;
  logic              slc_func;
  logic [N-1:0]      slc_a;
  logic [N-1:0]      slc_b;
  logic              slc_c;
  logic [N+1:0]      slc_result;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [SLICES-1:0] lane_flags;
  logic              ovf_obs;
`ifdef ADDSUB_SEQ_OVF_EN
  logic              res_ovf;
  assign ovf_obs = res_ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  addsub_slice_sequencer #(.N(N), .SLICES(SLICES)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .mode_func(mode_func), .func_lanes(func_lanes),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .slc_mode(slc_mode), .slc_mode_func(slc_mode_func), .slc_func(slc_func),
    .slc_a(slc_a), .slc_b(slc_b), .slc_c(slc_c), .slc_result(slc_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .lane_flags(lane_flags)
`ifdef ADDSUB_SEQ_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  // Shared slice model: add -> a+b+c; subtract -> a-b-c as an N+2-bit two's-complement value.
  always_comb begin
    if (!(slc_mode ? slc_func : slc_mode_func))
      slc_result = {1'b0, {1'b0, slc_a} + {1'b0, slc_b} + {{N{1'b0}}, slc_c}};
    else
      slc_result = {2'b00, slc_a} - {2'b00, slc_b} - {{(N+1){1'b0}}, slc_c};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference built from whole-operand arithmetic, independent of the slice walk.
  function automatic exp_t ref_model(input logic md, input logic mf, input logic [SLICES-1:0] fl,
                                     input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W+1:0] lo_a, lo_b, msk, t;
    logic [N:0]   lt;
    e = '0;
    if (!md) begin
      e.data = mf ? (a - b - W'(c)) : (a + b + W'(c));
      for (int k = 0; k < SLICES; k++) begin
        msk  = ((W+2)'(1) << ((k + 1) * N)) - (W+2)'(1);
        lo_a = {2'b00, a} & msk;
        lo_b = {2'b00, b} & msk;
        t    = lo_a + lo_b + (W+2)'(c);
        e.flags[k] = mf ? (lo_a < lo_b + (W+2)'(c)) : t[(k + 1) * N];
      end
      if (mf) e.ovf = (a[W-1] != b[W-1]) && (e.data[W-1] != a[W-1]);
      else    e.ovf = (a[W-1] == b[W-1]) && (e.data[W-1] != a[W-1]);
    end else begin
      for (int k = 0; k < SLICES; k++) begin
        if (fl[k]) begin
          e.data[k*N +: N] = a[k*N +: N] - b[k*N +: N];
          e.flags[k]       = a[k*N +: N] < b[k*N +: N];
        end else begin
          lt               = {1'b0, a[k*N +: N]} + {1'b0, b[k*N +: N]};
          e.data[k*N +: N] = lt[N-1:0];
          e.flags[k]       = lt[N];
        end
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] d, input logic [SLICES-1:0] f, input logic o);
    exp_t e;
    e.data = d; e.flags = f; e.ovf = o;
    return e;
  endfunction

  // Issue one request, check latency and stall behaviour, then pop and compare at the handshake.
  task automatic req(input logic md, input logic mf, input logic [SLICES-1:0] fl,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input int stall, input bit hold_start);
    int   lat;
    logic [W-1:0]      d0;
    logic [SLICES-1:0] f0;
    exp_t e;
    @(negedge clk);
    mode = md; mode_func = mf; func_lanes = fl; op_a = a; op_b = b; cin = c;
    start_valid = 1'b1;
    check("start_ready_idle", start_ready, 1'b1);
    @(posedge clk);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (!hold_start) start_valid = 1'b0;
      else begin op_a = ~a; op_b = ~b; end
      if (res_valid) break;
      check("start_ready_run", start_ready, 1'b0);
      if (md) check("slc_c_simd", slc_c, 1'b0);
      lat++;
    end
    check("latency", lat, SLICES);
    if (lat >= 20) begin
      start_valid = 1'b0;
      return;
    end
    d0 = res_data;
    f0 = lane_flags;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_data", res_data, d0);
      check("stall_flags", lane_flags, f0);
      check("stall_ready", start_ready, 1'b0);
      check("stall_valid", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    if (sb.size() == 0) check("sb_empty", 1'b1, 1'b0);
    else begin
      e = sb.pop_front();
      check("res_data", res_data, e.data);
      check("lane_flags", lane_flags, e.flags);
`ifdef ADDSUB_SEQ_OVF_EN
      check("res_ovf", ovf_obs, e.ovf);
`endif
    end
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop", res_valid, 1'b0);
    check("ready_back", start_ready, 1'b1);
    start_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [SLICES-1:0] rf;
    logic rm, rmf, rc;
    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    mode = 1'b0; mode_func = 1'b0; func_lanes = '0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, '0);
    check("rst_lane_flags", lane_flags, '0);
    check("rst_slc_a", slc_a, '0);
    rst = 1'b0;

    // Full-width add with carry ripple.
    sb.push_back(mk(16'h0100, 4'b0011, 1'b0));
    req(1'b0, 1'b0, 4'b0000, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    // Two full-width subtracts.
    sb.push_back(mk(16'h0FFF, 4'b0111, 1'b0));
    req(1'b0, 1'b1, 4'b0000, 16'h1000, 16'h0001, 1'b0, 0, 1'b0);
    sb.push_back(mk(16'hFFFF, 4'b1111, 1'b0));
    req(1'b0, 1'b1, 4'b0000, 16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    // SIMD lanes.
    sb.push_back(mk(16'h410E, 4'b0100, 1'b0));
    req(1'b1, 1'b0, 4'b1010, 16'h5F3A, 16'h1234, 1'b0, 0, 1'b0);
    // Backpressure with start_valid held high in DONE.
    sb.push_back(mk(16'h0100, 4'b0011, 1'b0));
    req(1'b0, 1'b0, 4'b0000, 16'h00FF, 16'h0001, 1'b0, 3, 1'b1);
    // Signed overflow corners.
    sb.push_back(mk(16'h8000, 4'b0111, 1'b1));
    req(1'b0, 1'b0, 4'b0000, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    sb.push_back(mk(16'h7FFF, 4'b0111, 1'b1));
    req(1'b0, 1'b1, 4'b0000, 16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    // Carry-in into slice 0.
    sb.push_back(mk(16'h0010, 4'b0001, 1'b0));
    req(1'b0, 1'b0, 4'b0000, 16'h000F, 16'h0000, 1'b1, 0, 1'b0);

    // Reset while running at k=2.
    @(negedge clk);
    mode = 1'b0; mode_func = 1'b0; op_a = 16'h0777; op_b = 16'h0333; cin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_slc_a", slc_a, 4'h7);
    rst = 1'b1;
    #1;
    check("midrun_rst_data", res_data, '0);
    check("midrun_rst_flags", lane_flags, '0);
    check("midrun_rst_slc_a", slc_a, '0);
    check("midrun_rst_slc_b", slc_b, '0);
    check("midrun_rst_slc_mode_func", slc_mode_func, 1'b0);
    check("midrun_rst_ready", start_ready, 1'b1);
    check("midrun_rst_valid", res_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(16'h0002, 4'b0000, 1'b0));
    req(1'b0, 1'b0, 4'b0000, 16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    // Random mix checked against the whole-operand reference.
    for (int i = 0; i < 12; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rf  = SLICES'($urandom);
      rm  = 1'($urandom);
      rmf = 1'($urandom);
      rc  = 1'($urandom);
      sb.push_back(ref_model(rm, rmf, rf, ra, rb, rc));
      req(rm, rmf, rf, ra, rb, rc, int'($urandom_range(0, 2)), 1'b0);
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/addsub_slice_sequencer.md
Name: addsub_slice_sequencer

Overview:
- Sequencer that time-multiplexes one shared N-bit add/sub slice (ports mode, mode_func, func, a, b, c, result[N+1:0]) over a W = N*SLICES operand.
- Full-width mode: chains carry/borrow LSB slice first to produce a W-bit sum/difference.
- SIMD mode: treats each slice as an independent lane with its own add/sub select.
- Sits between the divider/multiplier control path and the shared add/sub slice; valid/ready on both request and result sides.

Parameters:
- N, 4, slice width in bits.
- SLICES, 4, slices per operand; W = N*SLICES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  request valid.
- start_ready  out  1  request accepted when high with start_valid.
- mode  in  1  0 = full-width chained, 1 = SIMD lanes.
- mode_func  in  1  full-width op: 0 = add, 1 = subtract.
- func_lanes  in  SLICES  SIMD per-lane op, bit k for lane k: 0 = add, 1 = subtract.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- cin  in  1  carry/borrow into slice 0 in full-width mode.
- slc_mode  out  1  to slice mode.
- slc_mode_func  out  1  to slice mode_func.
- slc_func  out  1  to slice func.
- slc_a  out  N  to slice a.
- slc_b  out  N  to slice b.
- slc_c  out  1  to slice c.
- slc_result  in  N+2  from slice result (combinational).
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_data  out  W  assembled result.
- lane_flags  out  SLICES  per-slice carry (add) or borrow (sub); lane_flags[SLICES-1] is the full-width carry/borrow out.

Behaviour:
- FSM states: IDLE, RUN, DONE. Counter k counts 0..SLICES-1.
- Reset (async, any state including mid-RUN):
  - state IDLE, k = 0.
  - start_ready = 1; res_valid = 0; res_data = 0; lane_flags = 0.
  - All slc_* outputs = 0; latched operands and carry register cleared.
- IDLE:
  - start_ready = 1.
  - On start_valid: latch mode, mode_func, func_lanes, op_a, op_b, cin; clear res_data and lane_flags; k = 0; go to RUN.
- RUN (start_ready = 0, one slice per cycle, slice k):
  - slc_a = A[k*N +: N], slc_b = B[k*N +: N].
  - slc_mode = latched mode; slc_mode_func = latched mode_func; slc_func = func_lanes[k].
  - slc_c:
    - full-width: cin for k = 0, else the carry register.
    - SIMD: always 0.
  - Flag extraction, with op = mode_func (full-width) or func_lanes[k] (SIMD):
    - add: flag = slc_result[N].
    - sub: flag = slc_result[N+1] (negative result means borrow).
  - At each edge: res_data[k*N +: N] <= slc_result[N-1:0]; lane_flags[k] <= flag; carry register <= flag; k++.
  - After the edge for k = SLICES-1: go to DONE.
- DONE:
  - res_valid = 1; res_data and lane_flags held stable while res_ready = 0.
  - start_ready = 0; start_valid is ignored.
  - On res_valid & res_ready: go to IDLE, res_valid = 0 next cycle.
- Latency:
  - res_valid rises exactly SLICES cycles after the accepting edge.
  - Minimum request spacing is SLICES + 2 cycles (accept, SLICES RUN cycles, DONE handshake).
- Outside RUN, slc_* outputs = 0.
- Arithmetic:
  - Full-width is modulo 2^W.
  - SIMD lane k is modulo 2^N, with no carry crossing lanes.
- SLICES = 1 is legal: RUN lasts one cycle.

Optional Feature:
- Macro: ADDSUB_SEQ_OVF_EN.
- Defined: adds output res_ovf (1 bit), registered with the last slice.
  - Full-width add: res_ovf = (a_msb == b_msb) & (r_msb != a_msb).
  - Full-width sub: res_ovf = (a_msb != b_msb) & (r_msb != a_msb).
  - MSBs are bit W-1 of the latched operands and the result.
  - SIMD mode: res_ovf = 0. Reset value 0; held in DONE.
- Not defined: port absent; no overflow logic.

Test Plan (N=4, SLICES=4):
- Full add: op_a=0x00FF, op_b=0x0001, cin=0, mode=0, mode_func=0 -> res_data=0x0100, lane_flags=4'b0011; res_valid exactly 4 cycles after accept.
- Full sub, two requests: 0x1000-0x0001 -> 0x0FFF, lane_flags=4'b0111; 0x0000-0x0001 -> 0xFFFF, lane_flags=4'b1111.
- SIMD: mode=1, func_lanes=4'b1010, op_a=0x5F3A, op_b=0x1234 -> res_data=0x410E, lane_flags=4'b0100; slc_c=0 on all four RUN cycles.
- Backpressure: res_ready held low 3 cycles in DONE with start_valid=1 -> res_data and lane_flags stable, start_ready=0, no new accept; accept only after the result handshake.
- Reset mid-RUN: assert rst at k=2 -> all outputs 0 immediately. After release, start_ready=1, and 0x0001+0x0001 -> 0x0002.
- With ADDSUB_SEQ_OVF_EN: 0x7FFF+0x0001 -> 0x8000, res_ovf=1; 0x8000-0x0001 -> 0x7FFF, res_ovf=1; SIMD request -> res_ovf=0.
